vga_sync_pattern: RTL and testbench

Downstream consumer of the horizontal/vertical pixel counters in the VGA pipeline, clocked by the 25 MHz divided pixel clock. Decodes `hcnt`/`vcnt` into active-low `hsync`/`vsync`, a display-enable, and pixel coordinates. It also generates a selectable 12-bit test pattern, including a bouncing square. All outputs are registered and mutually aligned, so the board pins see a glitch-free 640x480@60 signal.

---
 rtl/vga_timing_pkg.sv | 39 +++
 rtl/vga_square_mover.sv | 37 +++
 rtl/vga_sync_pattern.sv | 108 ++++++++++
 tb/tb_vga_sync_pattern.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/vga_timing_pkg.sv
// vga_timing_pkg: 640x480@60 timing constants, pattern mode encodings and colour-bar table.
// Contents:
//   H_*/V_*        porch, sync and visible widths plus derived totals and sync start/end
//   SQ_*           bouncing-square size, travel limits and colours
//   mode_e         pattern select encodings
//   BAR_RGB        eight colour-bar colours, index 0 is the leftmost bar
package vga_timing_pkg;
  localparam int H_VISIBLE    = 640;
  localparam int H_FP         = 16;
  localparam int H_SYNC       = 96;
  localparam int H_BP         = 48;
  localparam int H_TOTAL      = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int H_SYNC_START = H_VISIBLE + H_FP;
  localparam int H_SYNC_END   = H_SYNC_START + H_SYNC - 1;
  localparam int V_VISIBLE    = 480;
  localparam int V_FP         = 10;
  localparam int V_SYNC       = 2;
  localparam int V_BP         = 33;
  localparam int V_TOTAL      = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int V_SYNC_START = V_VISIBLE + V_FP;
  localparam int V_SYNC_END   = V_SYNC_START + V_SYNC - 1;
  localparam int SQ_SIZE      = 32;
  localparam int SQ_X_MAX     = H_VISIBLE - SQ_SIZE;
  localparam int SQ_Y_MAX     = V_VISIBLE - SQ_SIZE;
  localparam int BAR_W        = H_VISIBLE / 8;
  localparam logic [11:0] SQ_RGB    = 12'hF00;
  localparam logic [11:0] SQ_BG_RGB = 12'h00F;
  typedef enum logic [1:0] {
    MODE_BARS   = 2'd0,
    MODE_CHECK  = 2'd1,
    MODE_SQUARE = 2'd2,
    MODE_SOLID  = 2'd3
  } mode_e;
  // Packed so that BAR_RGB[0] is white and BAR_RGB[7] is black.
  localparam logic [7:0][11:0] BAR_RGB = {
    12'h000, 12'h00F, 12'hF00, 12'hF0F,
    12'h0F0, 12'h0FF, 12'hFF0, 12'hFFF
  };
endpackage

// File: rtl/vga_square_mover.sv
// vga_square_mover: bouncing-square position, advanced one pixel per axis on each step.
// Ports:
//   clk   in   pixel clock
//   rst   in   asynchronous active-low reset -> position (0,0), both directions plus
//   step  in   one-cycle frame pulse that advances the square
//   sq_x  out  square left column, 0..608
//   sq_y  out  square top line, 0..448
import vga_timing_pkg::*;
module vga_square_mover (
  input  logic       clk,
  input  logic       rst,
  input  logic       step,
  output logic [9:0] sq_x,
  output logic [9:0] sq_y
);
  logic [9:0] r_x, r_y;
  logic       r_dir_x, r_dir_y;
  logic [9:0] w_nx, w_ny;
  // Direction bit high means moving toward zero.
  assign w_nx = r_dir_x ? r_x - 10'd1 : r_x + 10'd1;
  assign w_ny = r_dir_y ? r_y - 10'd1 : r_y + 10'd1;
  // Direction flips on the step that lands on a limit, so the limit is shown for one frame.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_x     <= '0;
      r_y     <= '0;
      r_dir_x <= 1'b0;
      r_dir_y <= 1'b0;
    end else if (step) begin
      r_x     <= w_nx;
      r_y     <= w_ny;
      r_dir_x <= w_nx == 10'(SQ_X_MAX) ? 1'b1 : w_nx == 10'd0 ? 1'b0 : r_dir_x;
      r_dir_y <= w_ny == 10'(SQ_Y_MAX) ? 1'b1 : w_ny == 10'd0 ? 1'b0 : r_dir_y;
    end
  assign sq_x = r_x;
  assign sq_y = r_y;
endmodule

// File: rtl/vga_sync_pattern.sv
// vga_sync_pattern: two-stage VGA sync decoder and test-pattern generator with aligned registered outputs.
// Ports:
//   clk        in   pixel clock
//   rst        in   asynchronous active-low reset
//   hcnt/vcnt  in   raw horizontal/vertical counts, 0..799 / 0..524
//   mode       in   pattern select, takes effect at the next frame tick
//   solid_rgb  in   colour for the solid pattern
//   hsync      out  horizontal sync, active low
//   vsync      out  vertical sync, active low
//   video_on   out  high inside the 640x480 window
//   pixel_x/y  out  visible coordinates, 0 while blanked
//   rgb        out  pixel colour, 0 while blanked
//   frame_tick out  one-cycle pulse per frame
import vga_timing_pkg::*;
module vga_sync_pattern (
  input  logic        clk,
  input  logic        rst,
  input  logic [9:0]  hcnt,
  input  logic [9:0]  vcnt,
  input  logic [1:0]  mode,
  input  logic [11:0] solid_rgb,
  output logic        hsync,
  output logic        vsync,
  output logic        video_on,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic [11:0] rgb,
  output logic        frame_tick
);
  logic        w_valid, w_h_act, w_v_act, w_hs, w_vs, w_ft;
  logic [9:0]  r_s1_x, r_s1_y;
  logic        r_s1_h_act, r_s1_v_act, r_s1_hs, r_s1_vs, r_s1_ft;
  mode_e       r_s1_mode, r_mode_q;
  logic [11:0] r_s1_solid;
  logic [9:0]  w_sq_x, w_sq_y;
  logic        w_video_on, w_in_sq;
  logic [2:0]  w_bar;
  logic [11:0] w_rgb;
  // Counts beyond the frame are blanking: syncs stay inactive and no tick is raised.
  assign w_valid = hcnt < 10'(H_TOTAL) && vcnt < 10'(V_TOTAL);
  assign w_h_act = hcnt < 10'(H_VISIBLE);
  assign w_v_act = vcnt < 10'(V_VISIBLE);
  assign w_hs    = w_valid && hcnt >= 10'(H_SYNC_START) && hcnt <= 10'(H_SYNC_END);
  assign w_vs    = w_valid && vcnt >= 10'(V_SYNC_START) && vcnt <= 10'(V_SYNC_END);
  assign w_ft    = hcnt == 10'd0 && vcnt == 10'(V_VISIBLE);
  // Mode and solid colour travel with their count sample so every output comes from one sample.
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      r_s1_x     <= '0;
      r_s1_y     <= '0;
      r_s1_h_act <= 1'b0;
      r_s1_v_act <= 1'b0;
      r_s1_hs    <= 1'b0;
      r_s1_vs    <= 1'b0;
      r_s1_ft    <= 1'b0;
      r_s1_mode  <= MODE_BARS;
      r_s1_solid <= '0;
    end else begin
      r_s1_x     <= hcnt;
      r_s1_y     <= vcnt;
      r_s1_h_act <= w_h_act;
      r_s1_v_act <= w_v_act;
      r_s1_hs    <= w_hs;
      r_s1_vs    <= w_vs;
      r_s1_ft    <= w_ft;
      r_s1_mode  <= mode_e'(mode);
      r_s1_solid <= solid_rgb;
    end
  // Position and mode update on the tick edge, during vertical blanking, so a frame never tears.
  vga_square_mover u_mover (
    .clk  (clk),
    .rst  (rst),
    .step (r_s1_ft),
    .sq_x (w_sq_x),
    .sq_y (w_sq_y)
  );
  assign w_video_on = r_s1_h_act & r_s1_v_act;
  assign w_bar      = 3'(r_s1_x / 10'(BAR_W));
  assign w_in_sq    = r_s1_x >= w_sq_x && r_s1_y >= w_sq_y &&
                      {1'b0, r_s1_x} < {1'b0, w_sq_x} + 11'(SQ_SIZE) &&
                      {1'b0, r_s1_y} < {1'b0, w_sq_y} + 11'(SQ_SIZE);
  always_comb
    w_rgb = !w_video_on              ? 12'h000 :
            r_mode_q == MODE_BARS    ? BAR_RGB[w_bar] :
            r_mode_q == MODE_CHECK   ? {12{r_s1_x[5] ^ r_s1_y[5]}} :
            r_mode_q == MODE_SQUARE  ? (w_in_sq ? SQ_RGB : SQ_BG_RGB) :
                                       r_s1_solid;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      hsync      <= 1'b1;
      vsync      <= 1'b1;
      video_on   <= 1'b0;
      pixel_x    <= '0;
      pixel_y    <= '0;
      rgb        <= '0;
      frame_tick <= 1'b0;
      r_mode_q   <= MODE_BARS;
    end else begin
      hsync      <= ~r_s1_hs;
      vsync      <= ~r_s1_vs;
      video_on   <= w_video_on;
      pixel_x    <= w_video_on ? r_s1_x : 10'd0;
      pixel_y    <= w_video_on ? r_s1_y : 10'd0;
      rgb        <= w_rgb;
      frame_tick <= r_s1_ft;
      r_mode_q   <= r_s1_ft ? r_s1_mode : r_mode_q;
    end
endmodule

// File: tb/tb_vga_sync_pattern.sv
// tb_vga_sync_pattern: randomized and directed bench against a frame-level behavioural model.
module tb_vga_sync_pattern;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [9:0]  hcnt = '0, vcnt = '0;
  logic [1:0]  mode = '0;
  logic [11:0] solid_rgb = '0;
  logic        hsync, vsync, video_on, frame_tick;
  logic [9:0]  pixel_x, pixel_y;
  logic [11:0] rgb;

  vga_sync_pattern dut (
    .clk(clk), .rst(rst), .hcnt(hcnt), .vcnt(vcnt), .mode(mode), .solid_rgb(solid_rgb),
    .hsync(hsync), .vsync(vsync), .video_on(video_on), .pixel_x(pixel_x),
    .pixel_y(pixel_y), .rgb(rgb), .frame_tick(frame_tick)
  );

  always #20 clk = ~clk;

  typedef struct packed {
    logic        lit;
    logic [11:0] lit_rgb;
    logic [9:0]  h;
    logic [9:0]  v;
    logic [35:0] out;
  } exp_t;

  exp_t q[$];
  int checks = 0;
  int errors = 0;
  int m_mode = 0;
  int nframes = 0;
  logic [11:0] bars [8] = '{12'hFFF, 12'hFF0, 12'h0FF, 12'h0F0, 12'hF0F, 12'hF00, 12'h00F, 12'h000};

  // Square position as a triangle wave of the number of frame ticks since reset.
  function automatic int sq_pos(int n, int lim);
    int p;
    p = n % (2 * lim);
    return p <= lim ? p : 2 * lim - p;
  endfunction

  function automatic logic [35:0] model(int h, int v, int md, logic [11:0] solid);
    logic valid, von, hs, vs, ft;
    logic [11:0] c;
    int sx, sy;
    valid = h < 800 && v < 525;
    von   = h < 640 && v < 480;
    hs    = valid && h >= 656 && h <= 751;
    vs    = valid && v >= 490 && v <= 491;
    ft    = h == 0 && v == 480;
    sx    = sq_pos(nframes, 608);
    sy    = sq_pos(nframes, 448);
    if (!von) c = 12'h000;
    else if (md == 0) c = bars[h / 80];
    else if (md == 1) c = (((h / 32) ^ (v / 32)) % 2 == 1) ? 12'hFFF : 12'h000;
    else if (md == 2) c = (h >= sx && h < sx + 32 && v >= sy && v < sy + 32) ? 12'hF00 : 12'h00F;
    else c = solid;
    return {!hs, !vs, von, von ? 10'(h) : 10'd0, von ? 10'(v) : 10'd0, c, ft};
  endfunction

  task automatic check(input exp_t e);
    logic [35:0] got;
    got = {hsync, vsync, video_on, pixel_x, pixel_y, rgb, frame_tick};
    checks++;
    if (got !== e.out) begin
      errors++;
      $display("FAIL pipe h=%0d v=%0d got hs=%b vs=%b von=%b x=%0d y=%0d rgb=%h ft=%b want hs=%b vs=%b von=%b x=%0d y=%0d rgb=%h ft=%b",
               e.h, e.v, got[35], got[34], got[33], got[32:23], got[22:13], got[12:1], got[0],
               e.out[35], e.out[34], e.out[33], e.out[32:23], e.out[22:13], e.out[12:1], e.out[0]);
    end
    if (e.lit) begin
      checks++;
      if (rgb !== e.lit_rgb) begin
        errors++;
        $display("FAIL literal h=%0d v=%0d rgb=%h want %h", e.h, e.v, rgb, e.lit_rgb);
      end
    end
  endtask

  // Each call: compare the sample driven two clocks ago, then drive a new sample.
  task automatic step(input int h, input int v, input logic [1:0] m, input logic [11:0] solid,
                      input logic lit = 1'b0, input logic [11:0] lit_rgb = 12'h000);
    exp_t e;
    @(negedge clk);
    if (q.size() == 2) check(q.pop_front());
    hcnt = 10'(h);
    vcnt = 10'(v);
    mode = m;
    solid_rgb = solid;
    e.lit = lit;
    e.lit_rgb = lit_rgb;
    e.h = 10'(h);
    e.v = 10'(v);
    e.out = model(h, v, m_mode, solid);
    q.push_back(e);
    if (h == 0 && v == 480) begin
      m_mode = int'(m);
      nframes++;
    end
  endtask

  task automatic check_reset(input string tag);
    checks++;
    if ({hsync, vsync, video_on, pixel_x, pixel_y, rgb, frame_tick} !== {1'b1, 1'b1, 1'b0, 20'd0, 12'h000, 1'b0}) begin
      errors++;
      $display("FAIL reset_%s hs=%b vs=%b von=%b x=%0d y=%0d rgb=%h ft=%b want hs=1 vs=1 von=0 x=0 y=0 rgb=000 ft=0",
               tag, hsync, vsync, video_on, pixel_x, pixel_y, rgb, frame_tick);
    end
  endtask

  task automatic release_reset();
    @(negedge clk);
    hcnt = '0;
    vcnt = '0;
    rst = 1'b1;
    q.delete();
    m_mode = 0;
    nframes = 0;
  endtask

  initial begin
    int vlist [11] = '{0, 10, 100, 479, 480, 481, 489, 490, 491, 492, 524};
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      hcnt = 10'($urandom);
      vcnt = 10'($urandom);
      mode = 2'($urandom);
      check_reset("power");
    end
    release_reset();
    step(0, 0, 2'd1, 12'h000);
    for (int i = 0; i < 11; i++)
      for (int h = 0; h < 800; h++) step(h, vlist[i], 2'd0, 12'h000);
    step(85, 10, 2'd0, 12'h000, 1'b1, 12'hFF0);
    step(639, 10, 2'd0, 12'h000, 1'b1, 12'h000);
    step(640, 10, 2'd0, 12'h000, 1'b1, 12'h000);
    step(100, 100, 2'd1, 12'h000, 1'b1, 12'hFF0);
    step(200, 100, 2'd1, 12'h000, 1'b1, 12'h0FF);
    step(0, 480, 2'd1, 12'h000);
    step(1, 480, 2'd1, 12'h000);
    step(32, 0, 2'd1, 12'h000, 1'b1, 12'hFFF);
    step(32, 32, 2'd1, 12'h000, 1'b1, 12'h000);
    step(64, 0, 2'd1, 12'h000, 1'b1, 12'h000);
    step(85, 10, 2'd0, 12'h000);
    @(negedge clk);
    #3 rst = 1'b0;
    #1 check_reset("async");
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      hcnt = 10'($urandom);
      vcnt = 10'($urandom);
      check_reset("held");
    end
    release_reset();
    step(85, 10, 2'd3, 12'h123, 1'b1, 12'hFF0);
    step(700, 600, 2'd3, 12'h123, 1'b1, 12'h000);
    step(900, 600, 2'd3, 12'h123, 1'b1, 12'h000);
    step(0, 600, 2'd3, 12'h123);
    step(700, 10, 2'd3, 12'h123);
    step(100, 491, 2'd3, 12'h123);
    while (nframes < 448) step(0, 480, 2'd2, 12'h000);
    step(448, 448, 2'd2, 12'h000, 1'b1, 12'hF00);
    step(479, 479, 2'd2, 12'h000, 1'b1, 12'hF00);
    step(448, 447, 2'd2, 12'h000, 1'b1, 12'h00F);
    step(0, 480, 2'd2, 12'h000);
    step(449, 447, 2'd2, 12'h000, 1'b1, 12'hF00);
    step(449, 446, 2'd2, 12'h000, 1'b1, 12'h00F);
    while (nframes < 608) step(0, 480, 2'd2, 12'h000);
    step(608, 288, 2'd2, 12'h000, 1'b1, 12'hF00);
    step(607, 288, 2'd2, 12'h000, 1'b1, 12'h00F);
    step(639, 319, 2'd2, 12'h000, 1'b1, 12'hF00);
    step(608, 320, 2'd2, 12'h000, 1'b1, 12'h00F);
    step(0, 480, 2'd2, 12'h000);
    step(607, 287, 2'd2, 12'h000, 1'b1, 12'hF00);
    step(639, 287, 2'd2, 12'h000, 1'b1, 12'h00F);
    step(606, 287, 2'd2, 12'h000, 1'b1, 12'h00F);
    for (int i = 0; i < 3000; i++) begin
      int h, v;
      h = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 799));
      v = ($urandom_range(0, 3) == 0) ? int'($urandom_range(0, 1023)) : int'($urandom_range(0, 524));
      if ($urandom_range(0, 49) == 0) begin
        h = 0;
        v = 480;
      end
      step(h, v, 2'($urandom), 12'($urandom));
    end
    step(0, 0, 2'd0, 12'h000);
    step(0, 0, 2'd0, 12'h000);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
